// File: rtl/tpg_pattern_engine.sv
// ATPG stimulus source: emits a programmed number of WIDTH-bit patterns
// (XNOR counter, binary counter, Fibonacci LFSR, walking-one) on a valid/ready stream.
module tpg_pattern_engine #(
    parameter int unsigned     WIDTH = 5,
    parameter logic [WIDTH-1:0] TAPS = WIDTH'(5'b10100),
    parameter int unsigned     CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] count,
    input  logic             pat_ready,
    output logic             pat_valid,
    output logic [WIDTH-1:0] pat_data,
    output logic [CNT_W-1:0] pat_idx,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] M_XNOR = 2'b00;
    localparam logic [1:0] M_BIN  = 2'b01;
    localparam logic [1:0] M_LFSR = 2'b10;
    localparam logic [1:0] M_WALK = 2'b11;

    localparam logic [WIDTH-1:0] N_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] N_ALL1 = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_n;
    logic [CNT_W-1:0] r_idx;
    logic [1:0]       r_mode;
    logic [CNT_W-1:0] r_cnt;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_n_nxt;
    logic [CNT_W-1:0] w_idx_nxt;
    logic [1:0]       w_mode_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic [WIDTH-1:0] w_seed_load;
    logic [WIDTH-1:0] w_n_step;
    logic [WIDTH-1:0] w_xnor;
    logic [WIDTH-1:0] w_pat;
    logic             w_last;

    // Initial generator state from the start-time mode; zero seeds are steered away from lockup.
    always_comb begin
        w_seed_load = seed;
        case (mode)
            M_XNOR:  w_seed_load = (seed == '0) ? N_ONE : seed;
            M_BIN:   w_seed_load = seed;
            M_LFSR:  w_seed_load = (seed == '0) ? N_ONE : seed;
            M_WALK:  w_seed_load = N_ONE;
            default: w_seed_load = seed;
        endcase
    end

    always_comb begin
        w_n_step = r_n;
        case (r_mode)
            M_XNOR:  w_n_step = (r_n == N_ALL1) ? N_ONE : r_n + N_ONE;
            M_BIN:   w_n_step = r_n + N_ONE;
            M_LFSR:  w_n_step = {r_n[WIDTH-2:0], ^(r_n & TAPS)};
            M_WALK:  w_n_step = {r_n[WIDTH-2:0], r_n[WIDTH-1]};
            default: w_n_step = r_n;
        endcase
    end

    // Adjacent-bit XNOR coding; the MSB compares against an implicit zero above it.
    always_comb begin
        w_xnor = '0;
        for (int i = 0; i < int'(WIDTH) - 1; i++) begin
            w_xnor[i] = ~(r_n[i] ^ r_n[i+1]);
        end
        w_xnor[WIDTH-1] = ~r_n[WIDTH-1];
    end

    assign w_pat  = (r_mode == M_XNOR) ? w_xnor : r_n;
    assign w_last = (r_idx == (r_cnt - CNT_W'(1)));

    always_comb begin
        w_state_nxt = r_state;
        w_n_nxt     = r_n;
        w_idx_nxt   = r_idx;
        w_mode_nxt  = r_mode;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (!abort && start) begin
                    w_mode_nxt  = mode;
                    w_cnt_nxt   = count;
                    w_idx_nxt   = '0;
                    w_n_nxt     = w_seed_load;
                    w_state_nxt = (count == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (pat_ready) begin
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_n_nxt   = w_n_step;
                        w_idx_nxt = r_idx + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_n     <= N_ONE;
            r_idx   <= '0;
            r_mode  <= M_XNOR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_n     <= w_n_nxt;
            r_idx   <= w_idx_nxt;
            r_mode  <= w_mode_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign pat_valid = (r_state == S_RUN);
    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign pat_data  = (r_state == S_RUN) ? w_pat : '0;
    assign pat_idx   = r_idx;

endmodule

// File: tb/tb_tpg_pattern_engine.sv
// Directed bench for tpg_pattern_engine: per-mode sequences, backpressure and edge controls.
module tb_tpg_pattern_engine;

    localparam int unsigned WIDTH = 5;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [1:0]       mode;
    logic [WIDTH-1:0] seed;
    logic [CNT_W-1:0] count;
    logic             pat_ready;
    logic             pat_valid;
    logic [WIDTH-1:0] pat_data;
    logic [CNT_W-1:0] pat_idx;
    logic             busy;
    logic             done;

    int n_chk  = 0;
    int n_pass = 0;

    logic [WIDTH-1:0] got [64];

    tpg_pattern_engine #(.WIDTH(WIDTH), .TAPS(5'b10100), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .mode      (mode),
        .seed      (seed),
        .count     (count),
        .pat_ready (pat_ready),
        .pat_valid (pat_valid),
        .pat_data  (pat_data),
        .pat_idx   (pat_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run(input logic [1:0] m, input logic [WIDTH-1:0] s, input int c);
        mode  = m;
        seed  = s;
        count = CNT_W'(c);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Stream c patterns at full throughput, checking handshake and index as we go.
    task automatic collect(input int c);
        pat_ready = 1'b1;
        for (int k = 0; k < c; k++) begin
            got[k] = pat_data;
            chk($sformatf("valid[%0d]", k), 32'(pat_valid), 32'd1);
            chk($sformatf("idx[%0d]", k), 32'(pat_idx), 32'(k));
            tick();
        end
    endtask

    task automatic expect_done();
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_in_done", 32'(busy), 32'd0);
        chk("valid_in_done", 32'(pat_valid), 32'd0);
        tick();
        chk("done_drop", 32'(done), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] exp_seq [6];
        logic [WIDTH-1:0] lnext;
        int dup;
        int zeros;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'b00;
        seed = '0; count = '0; pat_ready = 1'b0;
        #3;
        chk("rst_valid", 32'(pat_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data", 32'(pat_data), 32'd0);
        chk("rst_idx", 32'(pat_idx), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // XNOR counter from seed 1
        begin_run(2'b00, 5'd1, 3);
        exp_seq[0] = 5'h1E; exp_seq[1] = 5'h1C; exp_seq[2] = 5'h1D;
        collect(3);
        for (int k = 0; k < 3; k++) chk($sformatf("xnor_data[%0d]", k), 32'(got[k]), 32'(exp_seq[k]));
        expect_done();
        chk("xnor_busy_after", 32'(busy), 32'd0);

        // XNOR counter wrap 31 -> 1
        begin_run(2'b00, 5'd31, 2);
        collect(2);
        chk("xnor_wrap0", 32'(got[0]), 32'h0F);
        chk("xnor_wrap1", 32'(got[1]), 32'h1E);
        expect_done();

        // LFSR, zero seed is forced to 1
        begin_run(2'b10, 5'd0, 31);
        collect(31);
        exp_seq[0] = 5'h01; exp_seq[1] = 5'h02; exp_seq[2] = 5'h04;
        exp_seq[3] = 5'h09; exp_seq[4] = 5'h12;
        for (int k = 0; k < 5; k++) chk($sformatf("lfsr_data[%0d]", k), 32'(got[k]), 32'(exp_seq[k]));
        dup = 0; zeros = 0;
        for (int i = 0; i < 31; i++) begin
            if (got[i] == '0) zeros++;
            for (int j = 0; j < i; j++) if (got[i] == got[j]) dup++;
        end
        chk("lfsr_distinct", 32'(dup), 32'd0);
        chk("lfsr_nonzero", 32'(zeros), 32'd0);
        lnext = {got[30][3:0], got[30][4] ^ got[30][2]};
        chk("lfsr_period", 32'(lnext), 32'h01);
        expect_done();

        // Walking one, seed ignored
        begin_run(2'b11, 5'h1A, 6);
        collect(6);
        exp_seq[0] = 5'h01; exp_seq[1] = 5'h02; exp_seq[2] = 5'h04;
        exp_seq[3] = 5'h08; exp_seq[4] = 5'h10; exp_seq[5] = 5'h01;
        for (int k = 0; k < 6; k++) chk($sformatf("walk_data[%0d]", k), 32'(got[k]), 32'(exp_seq[k]));
        expect_done();

        // Binary counter wrap
        begin_run(2'b01, 5'd31, 2);
        collect(2);
        chk("bin_wrap0", 32'(got[0]), 32'h1F);
        chk("bin_wrap1", 32'(got[1]), 32'h00);
        expect_done();

        // Backpressure holds pattern and index
        pat_ready = 1'b0;
        begin_run(2'b01, 5'd5, 3);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp_hold_data[%0d]", k), 32'(pat_data), 32'h05);
            chk($sformatf("bp_hold_idx[%0d]", k), 32'(pat_idx), 32'd0);
            chk($sformatf("bp_hold_valid[%0d]", k), 32'(pat_valid), 32'd1);
            tick();
        end
        collect(3);
        chk("bp_data0", 32'(got[0]), 32'h05);
        chk("bp_data1", 32'(got[1]), 32'h06);
        chk("bp_data2", 32'(got[2]), 32'h07);
        expect_done();

        // count == 0 goes straight to DONE
        pat_ready = 1'b1;
        begin_run(2'b01, 5'd3, 0);
        chk("zero_valid", 32'(pat_valid), 32'd0);
        expect_done();
        chk("zero_valid_after", 32'(pat_valid), 32'd0);

        // Abort at pat_idx 1 of 5
        begin_run(2'b01, 5'd0, 5);
        tick();
        chk("abort_idx", 32'(pat_idx), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", 32'(pat_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_no_done", 32'(done), 32'd0);
        tick();
        chk("abort_no_done2", 32'(done), 32'd0);

        // Start during RUN is ignored
        pat_ready = 1'b0;
        begin_run(2'b01, 5'd10, 3);
        start = 1'b1; mode = 2'b11; seed = 5'd0; count = CNT_W'(9);
        pat_ready = 1'b1;
        chk("sdr_data0", 32'(pat_data), 32'd10);
        tick();
        chk("sdr_data1", 32'(pat_data), 32'd11);
        start = 1'b0;
        tick();
        chk("sdr_data2", 32'(pat_data), 32'd12);
        chk("sdr_idx2", 32'(pat_idx), 32'd2);
        tick();
        expect_done();

        // Asynchronous reset mid-run
        begin_run(2'b01, 5'd7, 5);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(pat_valid), 32'd0);
        chk("arst_data", 32'(pat_data), 32'd0);
        chk("arst_idx", 32'(pat_idx), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        tick();
        chk("arst_no_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("arst_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tpg_pattern_engine.md
Name: tpg_pattern_engine

Overview:
- Parametrised ATPG stimulus source: emits a programmed number of WIDTH-bit test patterns on a valid/ready stream.
- Pattern modes: XNOR-coded counter, raw binary counter, maximal-length Fibonacci LFSR, walking-one.
- Start/abort control with busy/done status. Sits between the test controller and the scan/boundary-scan input register.

Parameters:
- WIDTH, 5, pattern width in bits (>=2).
- TAPS, 5'b10100, LFSR feedback mask (bit i set = n[i] XORed into feedback); default is maximal length (31) for WIDTH=5.
- CNT_W, 16, width of pattern count and index.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; honoured only in IDLE.
- abort  in  1  synchronous stop; return to IDLE with no done pulse.
- mode  in  2  00 XNOR counter, 01 binary counter, 10 LFSR, 11 walking-one; sampled at start.
- seed  in  WIDTH  initial state; sampled at start.
- count  in  CNT_W  patterns to emit; sampled at start.
- pat_ready  in  1  consumer accepts pattern.
- pat_valid  out  1  pat_data is valid.
- pat_data  out  WIDTH  current pattern.
- pat_idx  out  CNT_W  index of current pattern, 0-based.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the last pattern is accepted.

Behaviour:
- Reset (async assert, sync release): state IDLE, n=1, pat_idx=0, mode_r=00, cnt_r=0, pat_valid=0, busy=0, done=0, pat_data=0.
- FSM IDLE/RUN/DONE. pat_valid=busy=(state==RUN). done=(state==DONE). pat_data=0 when not RUN.
- IDLE & start, cycle t:
  - Latch mode, count. pat_idx<=0.
  - count==0: go to DONE; no pattern is emitted.
  - Otherwise go to RUN; first pattern valid at t+1.
- Seed load by mode:
  - 00: n<=seed, or 1 if seed==0.
  - 01: n<=seed.
  - 10: n<=seed, or 1 if seed==0 (LFSR lockup guard).
  - 11: n<=1; seed ignored.
- Transfer = pat_valid & pat_ready in RUN.
  - No transfer: n, pat_idx and pat_data hold stable.
  - Transfer with pat_idx==cnt_r-1: go to DONE.
  - Other transfers: n<=next(n), pat_idx<=pat_idx+1.
- next(n):
  - 00: n==2^WIDTH-1 -> 1, else n+1. Range 1..2^WIDTH-1; zero is never visited.
  - 01: n+1 modulo 2^WIDTH, full range.
  - 10: {n[WIDTH-2:0], ^(n & TAPS)}.
  - 11: rotate left by 1.
- pat_data in RUN, combinational from registers:
  - 00: bit i = ~(n[i]^n[i+1]) for i<WIDTH-1; MSB = ~n[WIDTH-1].
  - 01, 10, 11: n.
- DONE lasts exactly one cycle (done=1), then IDLE. start during DONE is ignored.
- start while RUN is ignored; mode/seed/count changes mid-run have no effect.
- abort has priority over transfer and start in the same cycle.
  - Aborting from RUN or DONE: go to IDLE next cycle, pat_valid drops, no done pulse. A DONE-cycle done output is still seen that cycle.
- rst_n low mid-run: immediate return to reset values; no done.

Test Plan:
- Mode 00, seed 1, count 3, pat_ready=1:
  - pat_data 0x1E, 0x1C, 0x1D on consecutive cycles; pat_idx 0,1,2.
  - done pulses one cycle after the third transfer; busy low afterward.
- Mode 00, seed 31, count 2 (wrap): pat_data 0x0F then 0x1E (n 31 -> 1).
- Mode 10, seed 0, count 31:
  - First patterns 0x01, 0x02, 0x04, 0x09, 0x12.
  - All 31 values distinct and nonzero; next(n) after the last equals 0x01.
- Mode 11, count 6: patterns 0x01, 0x02, 0x04, 0x08, 0x10, 0x01. Mode 01, seed 31, count 2: 0x1F, 0x00.
- Backpressure, mode 01, seed 5, count 3:
  - Hold pat_ready=0 for 4 cycles: pat_data stays 0x05, pat_idx stays 0.
  - Release ready: 0x05, 0x06, 0x07 are accepted.
- Edge controls:
  - count=0 start: done at t+1, pat_valid never high.
  - abort at pat_idx=1 of count 5: pat_valid=0 next cycle, no done.
  - rst_n low mid-run: all outputs 0 asynchronously.
  - start during RUN: ignored.
